dmem_arbiter: RTL and testbench

//   Shares the single-port data memory between two requesters: port 0 (core

---
 rtl/dmem_pkg.sv | 28 ++
 rtl/dmem_rr_arb.sv | 35 +++
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory arbiter: access widths, FSM states
// and the alignment rule applied to incoming requests.
package dmem_pkg;

    localparam logic [1:0] MASK_BYTE    = 2'b00;
    localparam logic [1:0] MASK_HALF    = 2'b01;
    localparam logic [1:0] MASK_WORD    = 2'b10;
    localparam logic [1:0] MASK_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } state_t;

    // Byte accesses can sit at any address; halves need addr[0]=0, words addr[1:0]=0.
    function automatic logic is_illegal(input logic [1:0] mm, input logic [1:0] addr_lo);
        logic res;
        case (mm)
            MASK_BYTE: res = 1'b0;
            MASK_HALF: res = addr_lo[0];
            MASK_WORD: res = (addr_lo != 2'b00);
            default:   res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// Two-way request arbiter: round-robin on contention, or strict port-0
// priority when FIXED_PRIO is set.
module dmem_rr_arb #(
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] i_valid,
    input  logic       i_enable,
    output logic [1:0] o_grant
);

    // Preferred port for the next contended grant; always the loser of the last grant.
    logic r_rr_ptr;

    always_comb begin
        o_grant = 2'b00;
        if (i_enable) begin
            if (i_valid == 2'b11) begin
                o_grant = ((FIXED_PRIO != 0) || !r_rr_ptr) ? 2'b01 : 2'b10;
            end else begin
                o_grant = i_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rr_ptr <= 1'b0;
        end else if (o_grant != 2'b00) begin
            r_rr_ptr <= o_grant[0];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the core LSU (port 0) and the
// DMA/debug loader (port 1); one memory access per granted request.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_ADDR_SIZE = 14,
    parameter int FIXED_PRIO    = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [1:0]                 req_valid,
    output logic [1:0]                 req_ready,
    input  logic [1:0]                 req_write,
    input  logic [1:0][1:0]            req_maskmode,
    input  logic [1:0]                 req_sext,
    input  logic [1:0][DATA_WIDTH-1:0] req_addr,
    input  logic [1:0][DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                 rsp_valid,
    input  logic [1:0]                 rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       mem_write,
    output logic                       mem_read,
    output logic [1:0]                 mem_maskmode,
    output logic                       mem_sext,
    output logic [DATA_WIDTH-1:0]      mem_address,
    output logic [DATA_WIDTH-1:0]      mem_write_data,
    input  logic [DATA_WIDTH-1:0]      mem_read_data,
    output state_t                     o_dbg_state
);

    // Only the byte-address bits the memory decodes are passed on.
    localparam int ABITS = (MEM_ADDR_SIZE + 2 < DATA_WIDTH) ? MEM_ADDR_SIZE + 2 : DATA_WIDTH;
    localparam logic [DATA_WIDTH-1:0] ADDR_MASK = DATA_WIDTH'((64'd1 << ABITS) - 64'd1);

    state_t                r_state;
    logic                  r_owner;
    logic [1:0]            r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_mem_write;
    logic                  r_mem_read;
    logic [1:0]            r_mem_maskmode;
    logic                  r_mem_sext;
    logic [DATA_WIDTH-1:0] r_mem_address;
    logic [DATA_WIDTH-1:0] r_mem_write_data;

    logic                  w_idle;
    logic [1:0]            w_grant;
    logic                  w_sel;
    logic                  w_illegal;

    assign w_idle = (r_state == ST_IDLE) && !reset;

    dmem_rr_arb #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk     (clk),
        .reset   (reset),
        .i_valid (req_valid),
        .i_enable(w_idle),
        .o_grant (w_grant)
    );

    assign w_sel     = w_grant[1];
    assign w_illegal = is_illegal(req_maskmode[w_sel], req_addr[w_sel][1:0]);
    assign req_ready = w_grant;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_owner          <= 1'b0;
            r_rsp_valid      <= 2'b00;
            r_rsp_rdata      <= '0;
            r_rsp_err        <= 1'b0;
            r_mem_write      <= 1'b0;
            r_mem_read       <= 1'b0;
            r_mem_maskmode   <= 2'b00;
            r_mem_sext       <= 1'b0;
            r_mem_address    <= '0;
            r_mem_write_data <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_owner <= w_sel;
                        if (w_illegal) begin
                            // Rejected without a memory cycle; respond straight away.
                            r_rsp_valid <= w_grant;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                            r_state     <= ST_RESP;
                        end else begin
                            r_mem_write      <= req_write[w_sel];
                            r_mem_read       <= ~req_write[w_sel];
                            r_mem_maskmode   <= req_maskmode[w_sel];
                            r_mem_sext       <= req_sext[w_sel];
                            r_mem_address    <= req_addr[w_sel] & ADDR_MASK;
                            r_mem_write_data <= req_wdata[w_sel];
                            r_rsp_err        <= 1'b0;
                            r_state          <= ST_ACCESS;
                        end
                    end
                end
                ST_ACCESS: begin
                    r_rsp_rdata      <= r_mem_write ? '0 : mem_read_data;
                    r_rsp_valid      <= r_owner ? 2'b10 : 2'b01;
                    r_mem_write      <= 1'b0;
                    r_mem_read       <= 1'b0;
                    r_mem_maskmode   <= 2'b00;
                    r_mem_sext       <= 1'b0;
                    r_mem_address    <= '0;
                    r_mem_write_data <= '0;
                    r_state          <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready[r_owner]) begin
                        r_rsp_valid <= 2'b00;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid      = r_rsp_valid;
    assign rsp_rdata      = r_rsp_rdata;
    assign rsp_err        = r_rsp_err;
    assign mem_write      = r_mem_write;
    assign mem_read       = r_mem_read;
    assign mem_maskmode   = r_mem_maskmode;
    assign mem_sext       = r_mem_sext;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_write_data;
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: single-port transaction table against a
// byte-lane memory model, plus reset, contention and fixed-priority sequences.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic              clk;
    logic              reset;
    logic [1:0]        req_valid, req_ready, req_write, req_sext, rsp_valid, rsp_ready;
    logic [1:0][1:0]   req_maskmode;
    logic [1:0][31:0]  req_addr, req_wdata;
    logic [31:0]       rsp_rdata, mem_address, mem_write_data, mem_read_data;
    logic              rsp_err, mem_write, mem_read, mem_sext;
    logic [1:0]        mem_maskmode;
    state_t            dbg_state;

    logic [1:0]        req_valid_fp, req_ready_fp, rsp_valid_fp, rsp_ready_fp;
    logic [31:0]       rsp_rdata_fp, mem_address_fp, mem_write_data_fp;
    logic              rsp_err_fp, mem_write_fp, mem_read_fp, mem_sext_fp;
    logic [1:0]        mem_maskmode_fp;
    state_t            dbg_state_fp;

    int n_vec = 0;
    int n_mis = 0;
    logic [1:0] exp_q[$];

    dmem_arbiter #(.DATA_WIDTH(32), .MEM_ADDR_SIZE(14), .FIXED_PRIO(0)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_maskmode(req_maskmode), .req_sext(req_sext), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_write(mem_write),
        .mem_read(mem_read), .mem_maskmode(mem_maskmode), .mem_sext(mem_sext),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data), .o_dbg_state(dbg_state)
    );

    // Second instance only exercises arbitration, so its memory returns zero.
    dmem_arbiter #(.DATA_WIDTH(32), .MEM_ADDR_SIZE(14), .FIXED_PRIO(1)) u_dut_fp (
        .clk(clk), .reset(reset),
        .req_valid(req_valid_fp), .req_ready(req_ready_fp), .req_write(2'b00),
        .req_maskmode({2'b10, 2'b10}), .req_sext(2'b00), .req_addr({32'h0, 32'h0}),
        .req_wdata({32'h0, 32'h0}), .rsp_valid(rsp_valid_fp), .rsp_ready(rsp_ready_fp),
        .rsp_rdata(rsp_rdata_fp), .rsp_err(rsp_err_fp), .mem_write(mem_write_fp),
        .mem_read(mem_read_fp), .mem_maskmode(mem_maskmode_fp), .mem_sext(mem_sext_fp),
        .mem_address(mem_address_fp), .mem_write_data(mem_write_data_fp),
        .mem_read_data(32'h0), .o_dbg_state(dbg_state_fp)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Data memory model: stores on negedge, combinational read, sext=1 means zero-extend.
    logic [31:0] mem [0:255];
    logic [31:0] mem_word, mem_shift;

    always_comb begin
        mem_word  = mem[mem_address[9:2]];
        mem_shift = mem_word >> (8 * mem_address[1:0]);
        case (mem_maskmode)
            2'b00:   mem_read_data = mem_sext ? {24'h0, mem_shift[7:0]} : {{24{mem_shift[7]}}, mem_shift[7:0]};
            2'b01:   mem_read_data = mem_sext ? {16'h0, mem_shift[15:0]} : {{16{mem_shift[15]}}, mem_shift[15:0]};
            default: mem_read_data = mem_word;
        endcase
    end

    always @(negedge clk) begin
        if (mem_write) begin
            case (mem_maskmode)
                2'b00:   mem[mem_address[9:2]][8 * mem_address[1:0] +: 8] <= mem_write_data[7:0];
                2'b01:   mem[mem_address[9:2]][16 * mem_address[1] +: 16] <= mem_write_data[15:0];
                default: mem[mem_address[9:2]] <= mem_write_data;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    typedef struct {
        int          port;
        logic        write;
        logic [1:0]  mm;
        logic        sext;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          hold;
    } vec_t;

    vec_t vecs[18];

    // Driver: one complete request/response on a single port, checking timing on the way.
    task automatic run_txn(input vec_t v);
        int cyc;
        logic [1:0] onehot;
        logic [31:0] held;
        onehot = (v.port == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        req_valid[v.port]    = 1'b1;
        req_write[v.port]    = v.write;
        req_maskmode[v.port] = v.mm;
        req_sext[v.port]     = v.sext;
        req_addr[v.port]     = v.addr;
        req_wdata[v.port]    = v.wdata;
        cyc = 0;
        @(negedge clk);
        while (req_ready[v.port] !== 1'b1 && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("req_ready", 32'(req_ready), 32'(onehot));
        @(posedge clk); #1;
        req_valid[v.port] = 1'b0;
        @(negedge clk);
        check("busy_no_ready", 32'(req_ready), 32'h0);
        if (v.exp_err) begin
            check("err_rsp_valid", 32'(rsp_valid), 32'(onehot));
            check("err_no_mem", {30'h0, mem_read, mem_write}, 32'h0);
        end else begin
            check("acc_mem_write", 32'(mem_write), 32'(v.write));
            check("acc_mem_read", 32'(mem_read), 32'(!v.write));
            check("acc_addr", mem_address, v.addr);
            check("acc_mask", 32'(mem_maskmode), 32'(v.mm));
            check("acc_sext", 32'(mem_sext), 32'(v.sext));
            if (v.write) check("acc_wdata", mem_write_data, v.wdata);
            check("acc_no_rsp", 32'(rsp_valid), 32'h0);
            @(negedge clk);
            check("rsp_valid", 32'(rsp_valid), 32'(onehot));
            check("rsp_mem_idle", {30'h0, mem_read, mem_write}, 32'h0);
            check("rsp_addr_idle", mem_address, 32'h0);
        end
        check("rsp_err", 32'(rsp_err), 32'(v.exp_err));
        check("rsp_rdata", rsp_rdata, v.exp_rdata);
        held = rsp_rdata;
        rsp_ready = ~onehot;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(rsp_valid), 32'(onehot));
            check("hold_rdata", rsp_rdata, v.exp_rdata);
        end
        rsp_ready = onehot;
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        check("rsp_done", 32'(rsp_valid), 32'h0);
        check("rsp_done_err", 32'(rsp_err), 32'h0);
    endtask

    initial begin
        int grants;
        logic [1:0] got, exp_p;

        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        reset = 1'b1;
        req_valid = 2'b00; req_write = 2'b00; req_sext = 2'b00; rsp_ready = 2'b00;
        req_maskmode = '0; req_addr = '0; req_wdata = '0;
        req_valid_fp = 2'b00; rsp_ready_fp = 2'b00;

        //            port wr    mm     sext  addr      wdata          err   rdata          hold
        vecs[0]  = '{0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 0};
        vecs[1]  = '{0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        1'b0, 32'hDEADBEEF, 3};
        vecs[2]  = '{1, 1'b0, 2'b01, 1'b0, 32'h03, 32'h0,        1'b1, 32'h00000000, 1};
        vecs[3]  = '{0, 1'b1, 2'b10, 1'b0, 32'h06, 32'hFFFFFFFF, 1'b1, 32'h00000000, 0};
        vecs[4]  = '{1, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0,        1'b1, 32'h00000000, 0};
        vecs[5]  = '{1, 1'b0, 2'b10, 1'b0, 32'h04, 32'h0,        1'b0, 32'h00000000, 0};
        vecs[6]  = '{0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h000001A5, 1'b0, 32'h00000000, 0};
        vecs[7]  = '{0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0,        1'b0, 32'hFFFFFFA5, 1};
        vecs[8]  = '{1, 1'b0, 2'b00, 1'b1, 32'h21, 32'h0,        1'b0, 32'h00000000, 0};
        vecs[9]  = '{1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h12348001, 1'b0, 32'h00000000, 0};
        vecs[10] = '{0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0,        1'b0, 32'hFFFF8001, 0};
        vecs[11] = '{0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0,        1'b0, 32'h00008001, 2};
        vecs[12] = '{1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        1'b0, 32'h800100A5, 0};
        vecs[13] = '{0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0,        1'b0, 32'h000000BE, 0};
        vecs[14] = '{1, 1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        1'b0, 32'hFFFFDEAD, 0};
        vecs[15] = '{1, 1'b0, 2'b00, 1'b0, 32'h23, 32'h0,        1'b0, 32'hFFFFFF80, 0};
        vecs[16] = '{0, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0,        1'b1, 32'h00000000, 0};
        vecs[17] = '{0, 1'b1, 2'b01, 1'b0, 32'h01, 32'h0000BEEF, 1'b1, 32'h00000000, 0};

        // Reset state, including a request presented while reset is held.
        repeat (2) @(posedge clk);
        #1 req_valid = 2'b11;
        @(negedge clk);
        check("rst_no_ready", 32'(req_ready), 32'h0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset = 1'b0;
        @(negedge clk);
        check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        check("rst_rsp_err", 32'(rsp_err), 32'h0);
        check("rst_mem_ctl", {28'h0, mem_maskmode, mem_read, mem_write}, 32'h0);
        check("rst_mem_sext", 32'(mem_sext), 32'h0);
        check("rst_mem_addr", mem_address, 32'h0);
        check("rst_mem_wdata", mem_write_data, 32'h0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        for (int i = 0; i < 18; i++) run_txn(vecs[i]);

        // Reset arriving during the ACCESS cycle of a store.
        @(posedge clk); #1;
        req_valid[0] = 1'b1; req_write[0] = 1'b1; req_maskmode[0] = 2'b10;
        req_addr[0] = 32'h40; req_wdata[0] = 32'h55;
        @(negedge clk);
        check("rsta_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset = 1'b1;
        @(negedge clk);
        check("rsta_in_access", 32'(mem_write), 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rsta_mem_ctl", {30'h0, mem_read, mem_write}, 32'h0);
        check("rsta_mem_addr", mem_address, 32'h0);
        check("rsta_mem_wdata", mem_write_data, 32'h0);
        check("rsta_state", 32'(dbg_state), 32'(ST_IDLE));
        for (int i = 0; i < 3; i++) begin
            check("rsta_no_rsp", 32'(rsp_valid), 32'h0);
            @(negedge clk);
        end

        // Round-robin contention: both ports request every cycle.
        exp_q = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        @(posedge clk); #1;
        req_write = 2'b00; req_maskmode = {2'b10, 2'b10}; req_addr = {32'h10, 32'h20};
        rsp_ready = 2'b11;
        req_valid = 2'b11;
        grants = 0;
        for (int c = 0; c < 60 && grants < 5; c++) begin
            @(negedge clk);
            if (req_ready != 2'b00) begin
                got = req_ready[1] ? 2'd1 : 2'd0;
                exp_p = exp_q.pop_front();
                check("rr_onehot", 32'(req_ready), req_ready[1] ? 32'h2 : 32'h1);
                check("rr_grant", 32'(got), 32'(exp_p));
                grants++;
                @(posedge clk); #1;
                if (grants == 5) req_valid = 2'b00;
            end
        end
        check("rr_grant_count", 32'(grants), 32'd5);
        repeat (4) @(posedge clk);
        #1 rsp_ready = 2'b00;

        // Fixed priority: port 1 only wins once port 0 drops its request.
        exp_q = '{2'd0, 2'd0, 2'd0, 2'd1};
        rsp_ready_fp = 2'b11;
        req_valid_fp = 2'b11;
        grants = 0;
        for (int c = 0; c < 60 && grants < 4; c++) begin
            @(negedge clk);
            if (req_ready_fp != 2'b00) begin
                got = req_ready_fp[1] ? 2'd1 : 2'd0;
                exp_p = exp_q.pop_front();
                check("fp_onehot", 32'(req_ready_fp), req_ready_fp[1] ? 32'h2 : 32'h1);
                check("fp_grant", 32'(got), 32'(exp_p));
                grants++;
                @(posedge clk); #1;
                if (grants == 3) req_valid_fp[0] = 1'b0;
                if (grants == 4) req_valid_fp = 2'b00;
            end
        end
        check("fp_grant_count", 32'(grants), 32'd4);
        repeat (4) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
